// File: rtl/unfold_result_arbiter.sv
// Round-robin collector of NUM_CH producer results into a DEPTH-entry FWFT FIFO tagged with source channel.
// A grant at edge N is on res after edge N if the FIFO was empty; no combinational path from ch_data to res.
// Grants stop when full, when ctrl=0, under manual_rst and during reset; res_ready never feeds ch_ready.
module unfold_result_arbiter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        manual_rst,
    input  logic                        ctrl,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*WIDTH-1:0]     ch_data,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic [WIDTH-1:0]            res,
    output logic [$clog2(NUM_CH)-1:0]   res_ch,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_dat_q [DEPTH];
    logic [CW-1:0]    mem_ch_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] last_grant_q, last_grant_d;

    logic [CW-1:0] grant_idx;
    logic          grant_found;
    logic          eligible;
    logic          push;
    logic          pop;
    int            scan_idx;

    assign eligible = ctrl & ~manual_rst & rst_n & (level_q < LW'(DEPTH));

    // Search starts one past the last granted channel so every valid producer gets a turn.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!grant_found && ch_valid[CW'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(scan_idx);
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        if (eligible && grant_found) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    assign push = eligible & grant_found;
    assign pop  = (level_q != '0) & res_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        last_grant_d = last_grant_q;
        if (manual_rst) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            last_grant_d = CW'(NUM_CH - 1);
        end else begin
            if (push) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                last_grant_d = grant_idx;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            last_grant_q <= CW'(NUM_CH - 1);
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Storage needs no reset: every read of it is masked by level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dat_q[wr_ptr_q] <= ch_data[int'(grant_idx)*WIDTH +: WIDTH];
            mem_ch_q[wr_ptr_q]  <= grant_idx;
        end
    end

    assign res_valid = (level_q != '0);
    assign res       = res_valid ? mem_dat_q[rd_ptr_q] : '0;
    assign res_ch    = res_valid ? mem_ch_q[rd_ptr_q]  : '0;
    assign level     = level_q;

endmodule
